// File: rtl/multi_alarm_clock_ctrl_if.sv
// Button/tick inputs and display/status outputs of the alarm clock controller.
// The master side (button detectors plus the display mux) drives the pulses; the
// slave side is the controller itself.
interface multi_alarm_clock_ctrl_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  tick_1hz;
  logic                  btn_c;
  logic                  btn_l;
  logic                  btn_r;
  logic                  btn_u;
  logic                  btn_d;
  logic [1:0]            hr_tens;
  logic [3:0]            hr_units;
  logic [2:0]            min_tens;
  logic [3:0]            min_units;
  logic [5:0]            sec_o;
  logic [2:0]            mode_o;
  logic [IDX_W-1:0]      alm_idx_o;
  logic [NUM_ALARMS-1:0] alm_en_o;
  logic                  ringing;
  logic                  buzz;

  modport master (
    output tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d,
    input  hr_tens, hr_units, min_tens, min_units, sec_o, mode_o,
           alm_idx_o, alm_en_o, ringing, buzz
  );

  modport slave (
    input  tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d,
    output hr_tens, hr_units, min_tens, min_units, sec_o, mode_o,
           alm_idx_o, alm_en_o, ringing, buzz
  );
endinterface

// File: rtl/multi_alarm_clock_ctrl.sv
// 24-hour clock with NUM_ALARMS independently enabled alarms, snooze and ring
// timeout. Time is kept in binary and converted to BCD for the 7-seg mux.
module multi_alarm_clock_ctrl #(
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input logic                     clk_200_hz,
  input logic                     rst,
  multi_alarm_clock_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HR   = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SEL_ALM  = 3'd3,
    ST_SET_AHR  = 3'd4,
    ST_SET_AMIN = 3'd5,
    ST_RING     = 3'd6
  } state_t;

  state_t                state_r;
  logic [4:0]            hr_r;
  logic [5:0]            min_r;
  logic [5:0]            sec_r;
  logic [4:0]            alm_hr_r  [NUM_ALARMS];
  logic [5:0]            alm_min_r [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_en_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  snz_vld_r;
  logic [4:0]            snz_hr_r;
  logic [5:0]            snz_min_r;
  logic [7:0]            ring_cnt_r;
  logic                  blink_r;

  logic       sel_c_s, sel_r_s, sel_l_s, sel_u_s, sel_d_s;
  logic       sec_wrap_s, hit_s, fire_s;
  logic [5:0] roll_min_s;
  logic [4:0] roll_hr_s;
  logic [6:0] snz_sum_s;
  logic [5:0] snz_min_s;
  logic [4:0] snz_hr_s;
  logic [4:0] disp_hr_s;
  logic [5:0] disp_min_s;
  logic [6:0] hr_bcd_s;
  logic [6:0] min_bcd_s;

  function automatic logic [4:0] inc_hr(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec_hr(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_min(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // Binary 0..59 to {tens[2:0], units[3:0]}.
  function automatic logic [6:0] to_bcd(input logic [5:0] v);
    return {3'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Button priority C > R > L > U > D: only the winner is acted on.
  always_comb begin
    sel_c_s = bus.btn_c;
    sel_r_s = ~bus.btn_c & bus.btn_r;
    sel_l_s = ~bus.btn_c & ~bus.btn_r & bus.btn_l;
    sel_u_s = ~bus.btn_c & ~bus.btn_r & ~bus.btn_l & bus.btn_u;
    sel_d_s = ~bus.btn_c & ~bus.btn_r & ~bus.btn_l & ~bus.btn_u & bus.btn_d;
  end

  // Minute-rollover time and the alarm/snooze match that fires the ring.
  always_comb begin
    sec_wrap_s = (sec_r == 6'd59);
    roll_min_s = inc_min(min_r);
    roll_hr_s  = (min_r == 6'd59) ? inc_hr(hr_r) : hr_r;
    hit_s      = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hit_s = hit_s | (alm_en_r[i] & (alm_hr_r[i] == roll_hr_s) & (alm_min_r[i] == roll_min_s));
    end
    hit_s  = hit_s | (snz_vld_r & (snz_hr_r == roll_hr_s) & (snz_min_r == roll_min_s));
    fire_s = (state_r == ST_RUN) & bus.tick_1hz & sec_wrap_s & hit_s;
  end

  // Snooze target: current HH:MM plus SNOOZE_MIN with 24-hour wrap.
  always_comb begin
    snz_sum_s = {1'b0, min_r} + 7'(SNOOZE_MIN);
    if (snz_sum_s >= 7'd60) begin
      snz_min_s = 6'(snz_sum_s - 7'd60);
      snz_hr_s  = inc_hr(hr_r);
    end else begin
      snz_min_s = snz_sum_s[5:0];
      snz_hr_s  = hr_r;
    end
  end

  // Display source: the viewed alarm slot in alarm-edit states, else the time.
  always_comb begin
    if ((state_r == ST_SEL_ALM) || (state_r == ST_SET_AHR) || (state_r == ST_SET_AMIN)) begin
      disp_hr_s  = alm_hr_r[idx_r];
      disp_min_s = alm_min_r[idx_r];
    end else begin
      disp_hr_s  = hr_r;
      disp_min_s = min_r;
    end
    hr_bcd_s  = to_bcd({1'b0, disp_hr_s});
    min_bcd_s = to_bcd(disp_min_s);
  end

  assign bus.hr_tens   = 2'(hr_bcd_s[6:4]);
  assign bus.hr_units  = hr_bcd_s[3:0];
  assign bus.min_tens  = min_bcd_s[6:4];
  assign bus.min_units = min_bcd_s[3:0];
  assign bus.sec_o     = sec_r;
  assign bus.mode_o    = state_r;
  assign bus.alm_idx_o = idx_r;
  assign bus.alm_en_o  = alm_en_r;
  assign bus.ringing   = (state_r == ST_RING);
  assign bus.buzz      = blink_r;

  // Controller FSM: timekeeping, edit ring, alarm fire, snooze and timeout.
  always_ff @(posedge clk_200_hz or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      hr_r       <= 5'd0;
      min_r      <= 6'd0;
      sec_r      <= 6'd0;
      alm_en_r   <= {NUM_ALARMS{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      snz_vld_r  <= 1'b0;
      snz_hr_r   <= 5'd0;
      snz_min_r  <= 6'd0;
      ring_cnt_r <= 8'd0;
      blink_r    <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hr_r[i]  <= 5'd0;
        alm_min_r[i] <= 6'd0;
      end
    end else begin
      // Time only advances while running or ringing; edit states freeze it.
      if (bus.tick_1hz && ((state_r == ST_RUN) || (state_r == ST_RING))) begin
        if (sec_wrap_s) begin
          sec_r <= 6'd0;
          min_r <= roll_min_s;
          hr_r  <= roll_hr_s;
        end else begin
          sec_r <= sec_r + 6'd1;
        end
      end
      case (state_r)
        ST_RUN: begin
          if (fire_s) begin
            state_r    <= ST_RING;
            snz_vld_r  <= 1'b0;
            ring_cnt_r <= 8'd0;
            blink_r    <= 1'b1;
          end else if (sel_c_s) begin
            state_r <= ST_SET_HR;
          end
        end
        ST_SET_HR: begin
          if (sel_c_s)      state_r <= ST_RUN;
          else if (sel_r_s) state_r <= ST_SET_MIN;
          else if (sel_l_s) state_r <= ST_SET_AMIN;
          else if (sel_u_s || sel_d_s) begin
            hr_r      <= sel_u_s ? inc_hr(hr_r) : dec_hr(hr_r);
            sec_r     <= 6'd0;
            snz_vld_r <= 1'b0;
          end
        end
        ST_SET_MIN: begin
          if (sel_c_s)      state_r <= ST_RUN;
          else if (sel_r_s) state_r <= ST_SEL_ALM;
          else if (sel_l_s) state_r <= ST_SET_HR;
          else if (sel_u_s || sel_d_s) begin
            min_r     <= sel_u_s ? inc_min(min_r) : dec_min(min_r);
            sec_r     <= 6'd0;
            snz_vld_r <= 1'b0;
          end
        end
        ST_SEL_ALM: begin
          if (sel_c_s)      state_r <= ST_RUN;
          else if (sel_r_s) state_r <= ST_SET_AHR;
          else if (sel_l_s) state_r <= ST_SET_MIN;
          else if (sel_u_s) idx_r <= (idx_r == IDX_W'(NUM_ALARMS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
          else if (sel_d_s) alm_en_r[idx_r] <= ~alm_en_r[idx_r];
        end
        ST_SET_AHR: begin
          if (sel_c_s)      state_r <= ST_RUN;
          else if (sel_r_s) state_r <= ST_SET_AMIN;
          else if (sel_l_s) state_r <= ST_SEL_ALM;
          else if (sel_u_s) alm_hr_r[idx_r] <= inc_hr(alm_hr_r[idx_r]);
          else if (sel_d_s) alm_hr_r[idx_r] <= dec_hr(alm_hr_r[idx_r]);
        end
        ST_SET_AMIN: begin
          if (sel_c_s)      state_r <= ST_RUN;
          else if (sel_r_s) state_r <= ST_SET_HR;
          else if (sel_l_s) state_r <= ST_SET_AHR;
          else if (sel_u_s) alm_min_r[idx_r] <= inc_min(alm_min_r[idx_r]);
          else if (sel_d_s) alm_min_r[idx_r] <= dec_min(alm_min_r[idx_r]);
        end
        ST_RING: begin
          if (sel_c_s) begin
            state_r <= ST_RUN;
            blink_r <= 1'b0;
          end else if (sel_r_s || sel_l_s || sel_u_s || sel_d_s) begin
            state_r   <= ST_RUN;
            blink_r   <= 1'b0;
            snz_vld_r <= 1'b1;
            snz_hr_r  <= snz_hr_s;
            snz_min_r <= snz_min_s;
          end else if (bus.tick_1hz) begin
            if ((ring_cnt_r + 8'd1) == 8'(RING_TIMEOUT_S)) begin
              state_r <= ST_RUN;
              blink_r <= 1'b0;
            end else begin
              ring_cnt_r <= ring_cnt_r + 8'd1;
              blink_r    <= ~blink_r;
            end
          end
        end
        default: begin
          state_r <= ST_RUN;
          blink_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_alarm_clock_ctrl.sv
// Directed-vector bench for multi_alarm_clock_ctrl (NUM_ALARMS=4, snooze 5 min,
// ring timeout 60 s). Expected values are worked out by hand below.
module tb_multi_alarm_clock_ctrl;
  localparam logic [5:0] V_T = 6'b100000;
  localparam logic [5:0] V_C = 6'b010000;
  localparam logic [5:0] V_R = 6'b001000;
  localparam logic [5:0] V_L = 6'b000100;
  localparam logic [5:0] V_U = 6'b000010;
  localparam logic [5:0] V_D = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  multi_alarm_clock_ctrl_if #(.NUM_ALARMS(4)) bus ();

  multi_alarm_clock_ctrl #(
    .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60)
  ) dut (
    .clk_200_hz(clk),
    .rst       (rst),
    .bus       (bus)
  );

  // 200 Hz is nominal; the bench only cares about cycle order.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Displayed HH:MM as BCD plus seconds.
  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".ht"}, int'(bus.hr_tens), h / 10);
    chk({tag, ".hu"}, int'(bus.hr_units), h % 10);
    chk({tag, ".mt"}, int'(bus.min_tens), m / 10);
    chk({tag, ".mu"}, int'(bus.min_units), m % 10);
    chk({tag, ".s"}, int'(bus.sec_o), s);
  endtask

  // One-cycle pulse on {tick,c,r,l,u,d}; returns at the negedge after the sampling edge.
  task automatic apply(input logic [5:0] v);
    @(negedge clk);
    {bus.tick_1hz, bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = v;
    @(negedge clk);
    {bus.tick_1hz, bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = 6'b0;
  endtask

  task automatic rep(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) apply(v);
  endtask

  initial begin
    {bus.tick_1hz, bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = 6'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk_time("rst", 0, 0, 0);
    chk("rst.mode", int'(bus.mode_o), 0);
    chk("rst.en", int'(bus.alm_en_o), 0);
    chk("rst.idx", int'(bus.alm_idx_o), 0);
    chk("rst.ring", int'(bus.ringing), 0);
    chk("rst.buzz", int'(bus.buzz), 0);

    // Three ticks, disabled alarms at 00:00 do nothing
    rep(V_T, 3);
    chk_time("t3", 0, 0, 3);
    chk("t3.mode", int'(bus.mode_o), 0);

    // Set 23:59 then roll over midnight
    apply(V_C);
    chk("sethr.mode", int'(bus.mode_o), 1);
    rep(V_U, 23);
    chk_time("hr23", 23, 0, 0);
    apply(V_R);
    chk("setmin.mode", int'(bus.mode_o), 2);
    apply(V_D);
    chk_time("min59", 23, 59, 0);
    apply(V_C);
    chk("run.mode", int'(bus.mode_o), 0);
    rep(V_T, 59);
    chk_time("2359_59", 23, 59, 59);
    apply(V_T);
    chk_time("midnight", 0, 0, 0);
    chk("midnight.mode", int'(bus.mode_o), 0);

    // Slot 1 = 07:30 disabled, slot 2 = 07:30 enabled
    apply(V_C); apply(V_R); apply(V_R);
    chk("selalm.mode", int'(bus.mode_o), 3);
    apply(V_U);
    chk("idx1", int'(bus.alm_idx_o), 1);
    apply(V_R);
    chk("setahr.mode", int'(bus.mode_o), 4);
    rep(V_U, 7);
    apply(V_R);
    chk("setamin.mode", int'(bus.mode_o), 5);
    rep(V_U, 30);
    chk_time("alm1", 7, 30, 0);
    apply(V_L); apply(V_L);
    apply(V_U);
    chk("idx2", int'(bus.alm_idx_o), 2);
    apply(V_D);
    chk("en2", int'(bus.alm_en_o), 4);
    apply(V_R); rep(V_U, 7); apply(V_R); rep(V_U, 30);
    chk_time("alm2", 7, 30, 0);
    apply(V_C);
    chk_time("back_run", 0, 0, 0);

    // Time to 07:29, fire on the 07:29:59 -> 07:30:00 tick
    apply(V_C); rep(V_U, 7); apply(V_R); rep(V_U, 29); apply(V_C);
    rep(V_T, 59);
    chk_time("0729_59", 7, 29, 59);
    chk("prefire.mode", int'(bus.mode_o), 0);
    apply(V_T);
    chk("fire.mode", int'(bus.mode_o), 6);
    chk("fire.ring", int'(bus.ringing), 1);
    chk("fire.buzz", int'(bus.buzz), 1);
    chk_time("fire", 7, 30, 0);

    // Blink toggles on tick; snooze with U, refire at 07:35:00
    apply(V_T);
    chk("blink.buzz", int'(bus.buzz), 0);
    chk("blink.ring", int'(bus.ringing), 1);
    apply(V_U);
    chk("snooze.mode", int'(bus.mode_o), 0);
    rep(V_T, 298);
    chk_time("0734_59", 7, 34, 59);
    chk("presnz.mode", int'(bus.mode_o), 0);
    apply(V_T);
    chk("snzfire.mode", int'(bus.mode_o), 6);
    chk_time("snzfire", 7, 35, 0);
    apply(V_C);
    chk("dismiss.mode", int'(bus.mode_o), 0);
    chk("dismiss.buzz", int'(bus.buzz), 0);
    rep(V_T, 300);
    chk_time("0740", 7, 40, 0);
    chk("norefire.mode", int'(bus.mode_o), 0);

    // C beats U in SET_MIN; minute untouched
    apply(V_C); apply(V_R);
    apply(V_C | V_U);
    chk("cu.mode", int'(bus.mode_o), 0);
    chk_time("cu", 7, 40, 0);

    // R beats L; idx wraps 3 -> 0
    apply(V_C);
    apply(V_R | V_L);
    chk("rl.mode", int'(bus.mode_o), 2);
    apply(V_R);
    apply(V_U);
    chk("idx3", int'(bus.alm_idx_o), 3);
    apply(V_U);
    chk("idxwrap", int'(bus.alm_idx_o), 0);
    chk_time("alm0", 0, 0, 0);
    apply(V_C);

    // Fire beats same-cycle C, then ring times out after 60 ticks
    apply(V_C); apply(V_R); rep(V_D, 11); apply(V_C);
    chk_time("0729", 7, 29, 0);
    rep(V_T, 59);
    apply(V_T | V_C);
    chk("firec.mode", int'(bus.mode_o), 6);
    rep(V_T, 59);
    chk("to59.mode", int'(bus.mode_o), 6);
    chk("to59.buzz", int'(bus.buzz), 0);
    apply(V_T);
    chk("timeout.mode", int'(bus.mode_o), 0);
    chk("timeout.ring", int'(bus.ringing), 0);
    chk_time("timeout", 7, 31, 0);
    apply(V_T);
    chk_time("adv", 7, 31, 1);

    // Ring again, then asynchronous reset mid-ring
    apply(V_C); apply(V_R); rep(V_D, 2); apply(V_C);
    rep(V_T, 60);
    chk("ring3.mode", int'(bus.mode_o), 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst.mode", int'(bus.mode_o), 0);
    chk("arst.ring", int'(bus.ringing), 0);
    chk("arst.buzz", int'(bus.buzz), 0);
    chk("arst.en", int'(bus.alm_en_o), 0);
    chk_time("arst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
